bp_fe_realigner: RTL and testbench

BP_FE_REALIGNER -- requirements
Module: bp_fe_realigner

---
 rtl/bp_fe_realigner.sv | 130 +++++++++++++
 tb/tb_bp_fe_realigner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_realigner.sv
// Front-end realigner: splits 4-byte fetch words into 16/32-bit RISC-V instructions,
// carrying a lone upper parcel across fetch words when a 32-bit instruction straddles them.
module bp_fe_realigner #(
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_pc_i,
  input  logic [31:0]              fetch_data_i,
  output logic                     fetch_ready_and_o,
  output logic                     instr_v_o,
  output logic [31:0]              instr_o,
  output logic [vaddr_width_p-1:0] instr_pc_o,
  output logic                     instr_compressed_o,
  input  logic                     instr_ready_and_i,
  output logic                     partial_o
);

  typedef enum logic [1:0] {EMPTY, LO, HI, STRADDLE} state_e;

  localparam logic [vaddr_width_p-1:0] pc_step2 = vaddr_width_p'(2);
  localparam logic [vaddr_width_p-1:0] pc_step4 = vaddr_width_p'(4);

  state_e                   state_r;
  logic [31:0]              word_r;
  logic [15:0]              hi_r;
  logic [vaddr_width_p-1:0] pc_r;

  logic lo_comp, hi_comp;
  logic fetch_rdy, instr_v;
  logic fetch_hs, instr_hs;

  assign lo_comp = (word_r[1:0] != 2'b11);
  assign hi_comp = (hi_r[1:0] != 2'b11);

  always_comb begin
    fetch_rdy          = 1'b0;
    instr_v            = 1'b0;
    instr_o            = word_r;
    instr_compressed_o = 1'b0;
    partial_o          = 1'b0;
    case (state_r)
      EMPTY: fetch_rdy = 1'b1;
      LO: begin
        instr_v = 1'b1;
        if (lo_comp) begin
          instr_o            = {16'h0, word_r[15:0]};
          instr_compressed_o = 1'b1;
        end
      end
      HI: begin
        if (hi_comp) begin
          instr_v            = 1'b1;
          instr_o            = {16'h0, hi_r};
          instr_compressed_o = 1'b1;
        end else begin
          partial_o = 1'b1;
          fetch_rdy = 1'b1;
        end
      end
      STRADDLE: begin
        instr_v = 1'b1;
        instr_o = {word_r[15:0], hi_r};
      end
      default: fetch_rdy = 1'b0;
    endcase
  end

  // Flush and reset kill both handshakes combinationally so nothing is loaded or consumed.
  assign fetch_ready_and_o = fetch_rdy & ~flush_i & reset_n_i;
  assign instr_v_o         = instr_v & ~flush_i & reset_n_i;
  assign instr_pc_o        = pc_r;

  assign fetch_hs = fetch_v_i & fetch_ready_and_o;
  assign instr_hs = instr_v_o & instr_ready_and_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= EMPTY;
    end else if (flush_i) begin
      state_r <= EMPTY;
    end else begin
      case (state_r)
        EMPTY:    if (fetch_hs) state_r <= fetch_pc_i[1] ? HI : LO;
        LO:       if (instr_hs) state_r <= lo_comp ? HI : EMPTY;
        HI: begin
          if (hi_comp) begin
            if (instr_hs) state_r <= EMPTY;
          end else if (fetch_hs) begin
            state_r <= STRADDLE;
          end
        end
        STRADDLE: if (instr_hs) state_r <= HI;
        default:  state_r <= EMPTY;
      endcase
    end
  end

  // Datapath holds no reset; state alone decides whether its contents are meaningful.
  always_ff @(posedge clk_i) begin
    case (state_r)
      EMPTY: begin
        if (fetch_hs) begin
          word_r <= fetch_data_i;
          pc_r   <= fetch_pc_i;
          if (fetch_pc_i[1]) hi_r <= fetch_data_i[31:16];
        end
      end
      LO: begin
        if (instr_hs && lo_comp) begin
          hi_r <= word_r[31:16];
          pc_r <= pc_r + pc_step2;
        end
      end
      HI: begin
        if (fetch_hs) word_r <= fetch_data_i;
      end
      STRADDLE: begin
        if (instr_hs) begin
          hi_r <= word_r[31:16];
          pc_r <= pc_r + pc_step4;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bp_fe_realigner.sv
// Directed bench for bp_fe_realigner: expected instructions are queued as stimulus is
// driven and popped whenever the DUT completes an instruction handshake.
module tb_bp_fe_realigner;

  localparam int VW = 39;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          flush_i;
  logic          fetch_v_i;
  logic [VW-1:0] fetch_pc_i;
  logic [31:0]   fetch_data_i;
  logic          fetch_ready_and_o;
  logic          instr_v_o;
  logic [31:0]   instr_o;
  logic [VW-1:0] instr_pc_o;
  logic          instr_compressed_o;
  logic          instr_ready_and_i;
  logic          partial_o;

  bp_fe_realigner #(.vaddr_width_p(VW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
    .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_data_i(fetch_data_i),
    .fetch_ready_and_o(fetch_ready_and_o),
    .instr_v_o(instr_v_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_compressed_o(instr_compressed_o), .instr_ready_and_i(instr_ready_and_i),
    .partial_o(partial_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0]   instr;
    logic [VW-1:0] pc;
    logic          comp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] instr, input logic [VW-1:0] pc, input logic comp);
    exp_t e;
    e.instr = instr; e.pc = pc; e.comp = comp;
    q.push_back(e);
  endtask

  // Sample on the falling edge; any completed instruction handshake is scored here.
  task automatic samp();
    exp_t e;
    @(negedge clk_i);
    if (instr_v_o && instr_ready_and_i) begin
      if (q.size() == 0) begin
        chk("unexpected_instr", {32'h0, instr_o}, 64'hDEAD);
      end else begin
        e = q.pop_front();
        chk("instr", {32'h0, instr_o}, {32'h0, e.instr});
        chk("instr_pc", 64'(instr_pc_o), 64'(e.pc));
        chk("instr_comp", 64'(instr_compressed_o), 64'(e.comp));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [VW-1:0] pc, input logic [31:0] data);
    fetch_v_i = 1'b1; fetch_pc_i = pc; fetch_data_i = data;
    samp();
    chk("fetch_ready", 64'(fetch_ready_and_o), 64'd1);
    adv();
    fetch_v_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n_i = 1'b0; flush_i = 1'b0; fetch_v_i = 1'b0;
    fetch_pc_i = '0; fetch_data_i = '0; instr_ready_and_i = 1'b1;
    #1;
    chk("rst_fetch_ready", 64'(fetch_ready_and_o), 64'd0);
    chk("rst_instr_v", 64'(instr_v_o), 64'd0);
    chk("rst_partial", 64'(partial_o), 64'd0);
    adv(); adv();
    reset_n_i = 1'b1;
    samp();
    chk("post_rst_ready", 64'(fetch_ready_and_o), 64'd1);
    chk("post_rst_instr_v", 64'(instr_v_o), 64'd0);
    adv();

    // Aligned 32-bit instruction
    expect_instr(32'h00A00093, 39'h1000, 1'b0);
    fetch(39'h1000, 32'h00A00093);
    samp();
    chk("lo32_no_ready", 64'(fetch_ready_and_o), 64'd0);
    adv();
    samp();
    chk("lo32_empty_ready", 64'(fetch_ready_and_o), 64'd1);
    chk("lo32_empty_v", 64'(instr_v_o), 64'd0);
    adv();

    // Two compressed parcels in one word
    expect_instr(32'h00000505, 39'h2000, 1'b1);
    expect_instr(32'h00004505, 39'h2002, 1'b1);
    fetch(39'h2000, 32'h45050505);
    samp(); adv();
    samp();
    chk("hi16_no_ready", 64'(fetch_ready_and_o), 64'd0);
    adv();
    samp();
    chk("cc_empty_ready", 64'(fetch_ready_and_o), 64'd1);
    adv();

    // Straddling 32-bit instruction followed by a compressed one
    fetch(39'h3002, 32'h0093BEEF);
    fetch_v_i = 1'b1; fetch_pc_i = 39'h3004; fetch_data_i = 32'h000100A0;
    samp();
    chk("str_partial", 64'(partial_o), 64'd1);
    chk("str_partial_v", 64'(instr_v_o), 64'd0);
    chk("str_partial_ready", 64'(fetch_ready_and_o), 64'd1);
    adv();
    fetch_v_i = 1'b0;
    expect_instr(32'h00A00093, 39'h3002, 1'b0);
    expect_instr(32'h00000001, 39'h3006, 1'b1);
    samp(); adv();
    samp(); adv();
    samp();
    chk("str_empty_ready", 64'(fetch_ready_and_o), 64'd1);
    adv();

    // Backpressure in STRADDLE
    fetch(39'h4002, 32'hABC70000);
    fetch(39'h4004, 32'h55551111);
    instr_ready_and_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("bp_v", 64'(instr_v_o), 64'd1);
      chk("bp_instr", {32'h0, instr_o}, 64'h1111ABC7);
      chk("bp_pc", 64'(instr_pc_o), 64'h4002);
      chk("bp_comp", 64'(instr_compressed_o), 64'd0);
      chk("bp_ready", 64'(fetch_ready_and_o), 64'd0);
      adv();
    end
    instr_ready_and_i = 1'b1;
    expect_instr(32'h1111ABC7, 39'h4002, 1'b0);
    expect_instr(32'h00005555, 39'h4006, 1'b1);
    samp(); adv();
    samp(); adv();

    // Flush while a partial is held, then flush coincident with a fetch
    fetch(39'h5002, 32'hFFFF0000);
    samp();
    chk("fl_partial", 64'(partial_o), 64'd1);
    adv();
    flush_i = 1'b1; fetch_v_i = 1'b1; fetch_pc_i = 39'h5004; fetch_data_i = 32'h00A00093;
    samp();
    chk("fl_ready", 64'(fetch_ready_and_o), 64'd0);
    chk("fl_v", 64'(instr_v_o), 64'd0);
    adv();
    flush_i = 1'b0; fetch_v_i = 1'b0;
    samp();
    chk("fl_partial_clr", 64'(partial_o), 64'd0);
    chk("fl_empty_ready", 64'(fetch_ready_and_o), 64'd1);
    chk("fl_empty_v", 64'(instr_v_o), 64'd0);
    adv();
    flush_i = 1'b1; fetch_v_i = 1'b1; fetch_pc_i = 39'h6000;
    samp();
    chk("fl2_ready", 64'(fetch_ready_and_o), 64'd0);
    adv();
    flush_i = 1'b0; fetch_v_i = 1'b0;
    samp();
    chk("fl2_no_load_v", 64'(instr_v_o), 64'd0);
    chk("fl2_ready_after", 64'(fetch_ready_and_o), 64'd1);
    adv();

    // PC wrap across the top of the address space
    fetch(39'h7F_FFFF_FFFE, 32'h00930000);
    expect_instr(32'h00A00093, 39'h7F_FFFF_FFFE, 1'b0);
    expect_instr(32'h00000001, 39'h2, 1'b1);
    fetch(39'h0, 32'h000100A0);
    samp(); adv();
    samp(); adv();

    // Asynchronous reset in STRADDLE
    fetch(39'h7002, 32'h00930000);
    fetch(39'h7004, 32'h000000A0);
    instr_ready_and_i = 1'b0;
    samp();
    chk("ar_v_before", 64'(instr_v_o), 64'd1);
    #1 reset_n_i = 1'b0;
    #1;
    chk("ar_v_async", 64'(instr_v_o), 64'd0);
    chk("ar_ready_async", 64'(fetch_ready_and_o), 64'd0);
    chk("ar_partial_async", 64'(partial_o), 64'd0);
    adv();
    reset_n_i = 1'b1;
    instr_ready_and_i = 1'b1;
    samp();
    chk("ar_empty_ready", 64'(fetch_ready_and_o), 64'd1);
    chk("ar_empty_v", 64'(instr_v_o), 64'd0);
    adv();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
